// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: width, FSM encodings
// and iteration counter width.
`ifndef SEQ_DIVIDER_PKG_SV
`define SEQ_DIVIDER_PKG_SV

package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

`endif

// File: rtl/seq_divider_adder.sv
// 32-bit ripple-carry adder; the divider uses it as a trial subtractor by
// feeding the inverted divisor with carry-in tied high.
module seq_divider_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] carry;

    assign carry[0] = i_cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_sum[i]     = i_a[i] ^ i_b[i] ^ carry[i];
        assign carry[i + 1] = (i_a[i] & i_b[i]) | (carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = carry[W];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/done handshake, divide-by-zero short-circuits straight to DONE.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] dvsr_n;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             carry_out;
    logic             cout;
    logic             ok;
    logic             last_step;

    // Shift out of rem's MSB is the (WIDTH+1)th bit of the partial remainder;
    // when set, the trial subtraction can never borrow.
    assign carry_out = rem[WIDTH-1];
    assign rem_sh    = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign dvsr_n    = ~dvsr;

    seq_divider_adder #(
        .W (WIDTH)
    ) u_sub (
        .i_a    (rem_sh),
        .i_b    (dvsr_n),
        .i_cin  (1'b1),
        .o_sum  (diff),
        .o_cout (cout)
    );

    assign ok        = carry_out | cout;
    assign rem_next  = ok ? diff : rem_sh;
    assign quo_next  = {quo[WIDTH-2:0], ok};
    assign last_step = (count == CNT_W'(WIDTH - 1));

    assign o_busy = (state == S_RUN);
    assign o_done = (state == S_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            count         <= '0;
            rem           <= '0;
            quo           <= '0;
            dvsr          <= '0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new start exactly like IDLE so back-to-back
                // operations lose no cycle.
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        dvsr          <= i_divisor;
                        o_div_by_zero <= 1'b0;
                        if (i_divisor != '0) begin
                            rem   <= '0;
                            quo   <= i_dividend;
                            count <= '0;
                            state <= S_RUN;
                        end else begin
                            o_quotient    <= '1;
                            o_remainder   <= i_dividend;
                            o_div_by_zero <= 1'b1;
                            state         <= S_DONE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 1'b1;
                    if (last_step) begin
                        o_quotient  <= quo_next;
                        o_remainder <= rem_next;
                        state       <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, handshake corner
// sequences, async reset abort and a random regression against a / and % model.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t tbl[11];

    seq_divider dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge: presents a one-cycle start, returns at the negedge
    // following the accepting edge with the inputs scrambled.
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Returns at the negedge where done is high (or after the bound expires).
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int busy_n;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;

        tbl[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        tbl[1]  = '{32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32'h7FFF_FFFE, 1'b0};
        tbl[2]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        tbl[3]  = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
        tbl[4]  = '{32'd1234,      32'd0,         32'hFFFF_FFFF, 32'd1234,      1'b1};
        tbl[5]  = '{32'd9,         32'd3,         32'd3,         32'd0,         1'b0};
        tbl[6]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
        tbl[7]  = '{32'd5,         32'hFFFF_FFFF, 32'd0,         32'd5,         1'b0};
        tbl[8]  = '{32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0,         1'b1};
        tbl[9]  = '{32'd7,         32'd7,         32'd1,         32'd0,         1'b0};
        tbl[10] = '{32'd6,         32'd7,         32'd0,         32'd6,         1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            pulse_start(tbl[i].a, tbl[i].b);
            wait_done(lat, busy_n);
            chk($sformatf("vec%0d latency", i), 32'(lat), tbl[i].dz ? 32'd0 : 32'd32);
            chk($sformatf("vec%0d busy cycles", i), 32'(busy_n), tbl[i].dz ? 32'd0 : 32'd32);
            chk($sformatf("vec%0d quotient", i), quotient, tbl[i].q);
            chk($sformatf("vec%0d remainder", i), remainder, tbl[i].r);
            chk($sformatf("vec%0d dbz", i), 32'(div_by_zero), 32'(tbl[i].dz));
            @(negedge clk);
            chk($sformatf("vec%0d done width", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d hold q", i), quotient, tbl[i].q);
        end

        // Start while busy is ignored; restart in DONE is accepted with no gap
        pulse_start(32'd50, 32'd5);
        repeat (10) @(negedge clk);
        chk("busy at iter10", 32'(busy), 32'd1);
        pulse_start(32'd99, 32'd4);
        wait_done(lat, busy_n);
        chk("ignored start latency", 32'(lat), 32'd21);
        chk("ignored start quotient", quotient, 32'd10);
        chk("ignored start remainder", remainder, 32'd0);
        pulse_start(32'd99, 32'd4);
        chk("restart busy no gap", 32'(busy), 32'd1);
        chk("restart done low", 32'(done), 32'd0);
        wait_done(lat, busy_n);
        chk("restart latency", 32'(lat), 32'd32);
        chk("restart quotient", quotient, 32'd24);
        chk("restart remainder", remainder, 32'd3);
        @(negedge clk);

        // Async reset mid-operation aborts without done
        pulse_start(32'd1000, 32'd3);
        repeat (16) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        chk("async rst quotient", quotient, 32'd0);
        chk("async rst remainder", remainder, 32'd0);
        chk("async rst dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_done(lat, busy_n);
        chk("no done after abort", 32'(lat), 32'd40);
        pulse_start(32'd1000, 32'd3);
        wait_done(lat, busy_n);
        chk("post rst latency", 32'(lat), 32'd32);
        chk("post rst quotient", quotient, 32'd333);
        chk("post rst remainder", remainder, 32'd1);
        @(negedge clk);

        // Random regression against plain arithmetic
        for (int n = 0; n < 800; n++) begin
            a = pick();
            b = pick();
            if (b == 0) begin
                eq = 32'hFFFF_FFFF;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            pulse_start(a, b);
            wait_done(lat, busy_n);
            chk($sformatf("rnd %0h/%0h latency", a, b), 32'(lat), (b == 0) ? 32'd0 : 32'd32);
            chk($sformatf("rnd %0h/%0h quotient", a, b), quotient, eq);
            chk($sformatf("rnd %0h/%0h remainder", a, b), remainder, er);
            chk($sformatf("rnd %0h/%0h dbz", a, b), 32'(div_by_zero), 32'(b == 0));
            @(negedge clk);
            chk($sformatf("rnd %0h/%0h done width", a, b), 32'(done), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
